// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: PC-source encodings, fetch FSM states,
// reset vector and opcode constants used by fetch and the controller.
package riscv_pkg;

   // Next-PC selection driven by the controller when an instruction is consumed
   localparam logic [1:0] PCSRC_SEQ  = 2'b00;   // pc + 4
   localparam logic [1:0] PCSRC_BR   = 2'b01;   // pc + imm_ext (branch / jal)
   localparam logic [1:0] PCSRC_JALR = 2'b10;   // alu_result with bit 0 cleared
   localparam logic [1:0] PCSRC_RSVD = 2'b11;   // reserved, treated as a fault

   // Default reset vector (must be word aligned)
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch unit states
   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_HOLD = 2'd2,
      FS_ERR  = 2'd3
   } fetch_state_e;

   // Base opcodes (instr[6:0]) shared with the controller
   localparam logic [6:0] OP_LOAD   = 7'b000_0011;
   localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
   localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OP_STORE  = 7'b010_0011;
   localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
   localparam logic [6:0] OP_LUI    = 7'b011_0111;
   localparam logic [6:0] OP_BRANCH = 7'b110_0011;
   localparam logic [6:0] OP_JALR   = 7'b110_0111;
   localparam logic [6:0] OP_JAL    = 7'b110_1111;

   // True when a byte address points at the start of a 32-bit word
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential, PC-relative, or jalr target, plus a fault
// flag for misaligned targets and the reserved selection.
module pc_next
   import riscv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_src,
   input  logic [31:0] imm_ext,
   input  logic [31:0] alu_result,
   output logic [31:0] next_pc,
   output logic        bad_target
);

   logic [31:0] target;
   logic        reserved;

   // Select the candidate target (wraps mod 2^32) and qualify it
   always_comb begin
      target   = pc + 32'd4;
      reserved = 1'b0;
      case (pc_src)
         PCSRC_SEQ:  target = pc + 32'd4;
         PCSRC_BR:   target = pc + imm_ext;
         PCSRC_JALR: target = alu_result & ~32'h1;
         default: begin
            target   = pc;
            reserved = 1'b1;
         end
      endcase
      next_pc    = target;
      bad_target = reserved || !is_word_aligned(target);
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory request
// at a time, holds the returned word for the core and steers the next PC.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst_n,
   // instruction memory request / response
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   // instruction presented to the core
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   // next-PC controls sampled on consume
   input  logic [1:0]  pc_src,
   input  logic [31:0] imm_ext,
   input  logic [31:0] alu_result,
   output logic        fetch_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         err_q, err_d;
   logic         req_valid_q;
   logic         instr_valid_q;

   logic [31:0]  next_pc;
   logic         bad_target;

   pc_next u_pc_next (
      .pc         (pc_q),
      .pc_src     (pc_src),
      .imm_ext    (imm_ext),
      .alu_result (alu_result),
      .next_pc    (next_pc),
      .bad_target (bad_target)
   );

   // Next-state logic: one request in flight, hold until consumed, trap on bad target
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      err_d   = err_q;
      case (state_q)
         FS_REQ: begin
            // req_valid_q is low for the first cycle after reset, so gate on it
            if (req_valid_q && imem_req_ready) begin
               state_d = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (imem_rsp_valid) begin
               instr_d = imem_rsp_data;
               state_d = FS_HOLD;
            end
         end
         FS_HOLD: begin
            if (instr_ready) begin
               if (bad_target) begin
                  err_d   = 1'b1;
                  state_d = FS_ERR;
               end else begin
                  pc_d    = next_pc;
                  state_d = FS_REQ;
               end
            end
         end
         default: begin
            // FS_ERR: parked until reset
            state_d = FS_ERR;
         end
      endcase
   end

   // State, PC, instruction and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FS_REQ;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         err_q         <= 1'b0;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         err_q         <= err_d;
         req_valid_q   <= (state_d == FS_REQ);
         instr_valid_q <= (state_d == FS_HOLD);
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign instr_valid    = instr_valid_q;
   assign instr          = instr_q;
   assign pc             = pc_q;
   assign fetch_err      = err_q;

   // Decoded fields and link address are derived directly from the registers
   assign op       = instr_q[6:0];
   assign funct3   = instr_q[14:12];
   assign funct7   = instr_q[31:25];
   assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven testbench for instr_fetch with a bench-driven memory.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  pc_src = 2'b00;
   logic [31:0] imm_ext = 32'h0;
   logic [31:0] alu_result = 32'h0;
   logic        fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .op             (op),
      .funct3         (funct3),
      .funct7         (funct7),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .pc_src         (pc_src),
      .imm_ext        (imm_ext),
      .alu_result     (alu_result),
      .fetch_err      (fetch_err)
   );

   typedef struct {
      logic        rst;       // reset before this row
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] alu;
      logic [31:0] exp_next;  // next request address (ignored when exp_err)
      logic        exp_err;
      int          rdly;      // cycles with imem_req_ready low
      int          rspdly;    // extra cycles before the response
      int          hold;      // cycles with instr_ready low
   } vec_t;

   vec_t vecs[14];

   // Memory contents: a distinct word per address
   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5A5A_1233;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      instr_ready    = 1'b0;
      #1;
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_fields", {11'h0, funct7, funct3, op}, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_plus4", pc_plus4, 32'h4);
      chk("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Accept the request for address a and return its word
   task automatic serve(input logic [31:0] a, input int rdly, input int rspdly);
      logic [31:0] w;
      w = word(a);
      chk("req_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("req_addr", imem_req_addr, a);
      for (int k = 0; k < rdly; k++) begin
         tick();
         chk("req_stall_valid", {31'h0, imem_req_valid}, 32'h1);
         chk("req_stall_addr", imem_req_addr, a);
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
      chk("wait_no_instr", {31'h0, instr_valid}, 32'h0);
      for (int k = 0; k < rspdly; k++) begin
         tick();
         chk("wait_idle_req", {31'h0, imem_req_valid}, 32'h0);
         chk("wait_idle_instr", {31'h0, instr_valid}, 32'h0);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = w;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      chk("hold_instr_valid", {31'h0, instr_valid}, 32'h1);
      chk("hold_instr", instr, w);
      chk("hold_pc", pc, a);
      chk("hold_pc_plus4", pc_plus4, a + 32'd4);
      chk("hold_op", {25'h0, op}, {25'h0, w[6:0]});
      chk("hold_funct3", {29'h0, funct3}, {29'h0, w[14:12]});
      chk("hold_funct7", {25'h0, funct7}, {25'h0, w[31:25]});
      chk("hold_no_req", {31'h0, imem_req_valid}, 32'h0);
   endtask

   task automatic consume(input logic [31:0] a, input int hold,
                          input logic [1:0] s, input logic [31:0] imm, input logic [31:0] alu);
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("stall_instr_valid", {31'h0, instr_valid}, 32'h1);
         chk("stall_instr", instr, word(a));
         chk("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
      end
      pc_src      = s;
      imm_ext     = imm;
      alu_result  = alu;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      pc_src      = 2'b00;
      imm_ext     = 32'h0;
      alu_result  = 32'h0;
   endtask

   logic [31:0] cur;

   initial begin
      //            rst   src    imm            alu            exp_next       err  rdly rsp hold
      vecs[0]  = '{1'b1, 2'b00, 32'h0,         32'h0,         32'h0000_0004, 1'b0, 0, 0, 0};
      vecs[1]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0000_0008, 1'b0, 1, 2, 1};
      vecs[2]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0000_000C, 1'b0, 0, 0, 0};
      vecs[3]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0000_0010, 1'b0, 0, 0, 0};
      vecs[4]  = '{1'b0, 2'b01, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 1'b0, 0, 0, 0};
      vecs[5]  = '{1'b0, 2'b10, 32'h0,         32'h0000_0101, 32'h0000_0100, 1'b0, 0, 1, 0};
      vecs[6]  = '{1'b0, 2'b01, 32'h0000_0040, 32'h0,         32'h0000_0140, 1'b0, 5, 0, 4};
      vecs[7]  = '{1'b0, 2'b01, 32'hFFFF_FEBC, 32'h0,         32'hFFFF_FFFC, 1'b0, 0, 0, 0};
      vecs[8]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 1'b0, 0, 0, 0};
      vecs[9]  = '{1'b0, 2'b10, 32'h0,         32'h0000_0103, 32'h0,         1'b1, 0, 0, 0};
      vecs[10] = '{1'b1, 2'b10, 32'h0,         32'h0000_0200, 32'h0000_0200, 1'b0, 0, 0, 0};
      vecs[11] = '{1'b0, 2'b01, 32'h0000_0002, 32'h0,         32'h0,         1'b1, 0, 0, 2};
      vecs[12] = '{1'b1, 2'b11, 32'h0,         32'h0,         32'h0,         1'b1, 0, 0, 0};
      vecs[13] = '{1'b1, 2'b10, 32'h0,         32'hFFFF_FFFF, 32'h0,         1'b1, 0, 0, 0};

      cur = 32'h0;
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].rst) begin
            do_reset();
            cur = 32'h0;
         end
         serve(cur, vecs[i].rdly, vecs[i].rspdly);
         consume(cur, vecs[i].hold, vecs[i].src, vecs[i].imm, vecs[i].alu);
         if (vecs[i].exp_err) begin
            chk("err_flag", {31'h0, fetch_err}, 32'h1);
            chk("err_instr_valid", {31'h0, instr_valid}, 32'h0);
            chk("err_pc_kept", pc, cur);
            imem_req_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
               chk("err_no_req", {31'h0, imem_req_valid}, 32'h0);
               tick();
            end
            imem_req_ready = 1'b0;
            chk("err_sticky", {31'h0, fetch_err}, 32'h1);
            $display("vec %0d: pc=%h src=%b -> fetch_err=%b", i, cur, vecs[i].src, fetch_err);
         end else begin
            chk("next_req_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("next_req_addr", imem_req_addr, vecs[i].exp_next);
            chk("next_no_err", {31'h0, fetch_err}, 32'h0);
            $display("vec %0d: pc=%h src=%b -> next=%h", i, cur, vecs[i].src, imem_req_addr);
            cur = vecs[i].exp_next;
         end
      end

      // Spurious responses in REQ and HOLD are ignored
      do_reset();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      chk("spur_req_instr_valid", {31'h0, instr_valid}, 32'h0);
      chk("spur_req_instr", instr, 32'h0);
      chk("spur_req_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("spur_req_addr", imem_req_addr, 32'h0);
      serve(32'h0, 0, 0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hCAFE_F00D;
      tick();
      imem_rsp_valid = 1'b0;
      chk("spur_hold_instr", instr, word(32'h0));
      chk("spur_hold_valid", {31'h0, instr_valid}, 32'h1);
      $display("spurious responses: instr=%h", instr);
      consume(32'h0, 0, 2'b00, 32'h0, 32'h0);
      serve(32'h4, 0, 0);
      consume(32'h4, 0, 2'b00, 32'h0, 32'h0);
      chk("pre_rst_addr", imem_req_addr, 32'h8);

      // Reset while waiting for a response: late response dropped, restart at 0
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk("rw_in_wait", {31'h0, imem_req_valid}, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rw_pc", pc, 32'h0);
      chk("rw_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("rw_instr_valid", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(32'h8);
      tick();
      imem_rsp_valid = 1'b0;
      chk("rw_drop_instr_valid", {31'h0, instr_valid}, 32'h0);
      chk("rw_drop_instr", instr, 32'h0);
      chk("rw_restart_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("rw_restart_addr", imem_req_addr, 32'h0);
      $display("reset in wait: restart addr=%h instr_valid=%b", imem_req_addr, instr_valid);
      serve(32'h0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
